// File: rtl/dsp_pkg.sv
// Shared widths and OPMODE field encodings for the DSP slice post-adder stage.
package dsp_pkg;
  localparam int P_W    = 48;
  localparam int M_W    = 36;
  localparam int AB_W   = 18;
  localparam int DCAT_W = 12;

  localparam logic [1:0] X_ZERO = 2'd0;
  localparam logic [1:0] X_M    = 2'd1;
  localparam logic [1:0] X_P    = 2'd2;
  localparam logic [1:0] X_DAB  = 2'd3;

  localparam logic [1:0] Z_ZERO = 2'd0;
  localparam logic [1:0] Z_PCIN = 2'd1;
  localparam logic [1:0] Z_P    = 2'd2;
  localparam logic [1:0] Z_C    = 2'd3;

  localparam int OPM_SUB = 7;
  localparam int OPM_CIN = 5;
endpackage

// File: rtl/dsp_pipe_reg.sv
// Width-parameterised register with clock enable, async active-high reset and
// a static bypass (EN=0 passes d_i straight through).
module dsp_pipe_reg #(
  parameter int W  = 1,
  parameter int EN = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  generate
    if (EN != 0) begin : g_reg
      logic [W-1:0] q_q;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)       q_q <= '0;
        else if (ce_i) q_q <= d_i;
      end
      assign q_o = q_q;
    end else begin : g_byp
      logic unused_byp;
      assign unused_byp = ^{CLK, RST, ce_i};
      assign q_o = d_i;
    end
  endgenerate
endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator of a DSP48A1-style slice: X/Z operand select, add/sub
// with carry-in, P register and carry-out. `define DSP_ACC_OVF_EN adds ACC_OVF.
module dsp_post_adder_acc
  import dsp_pkg::*;
#(
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [7:0]  OPMODE,
  input  logic [35:0] M,
  input  logic [17:0] D,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
`ifdef DSP_ACC_OVF_EN
  output logic        ACC_OVF,
`endif
  output logic        CARRYOUTF
);
  logic [7:0]     opm;
  logic           cin_src, cin, co;
  logic [P_W-1:0] x, z, p_q;
  logic [P_W:0]   r;

  dsp_pipe_reg #(.W(8), .EN(OPMODEREG)) u_opm (
    .CLK(CLK), .RST(RST), .ce_i(CEOPMODE), .d_i(OPMODE), .q_o(opm));

  // Carry-in from OPMODE follows the (possibly registered) OPMODE value.
  assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : opm[OPM_CIN];

  dsp_pipe_reg #(.W(1), .EN(CARRYINREG)) u_cin (
    .CLK(CLK), .RST(RST), .ce_i(CECARRYIN), .d_i(cin_src), .q_o(cin));

  always_comb begin
    x = '0;
    case (opm[1:0])
      X_ZERO:  x = '0;
      X_M:     x = {{(P_W-M_W){M[M_W-1]}}, M};
      X_P:     x = p_q;
      X_DAB:   x = {D[DCAT_W-1:0], A, B};
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    case (opm[3:2])
      Z_ZERO:  z = '0;
      Z_PCIN:  z = PCIN;
      Z_P:     z = p_q;
      Z_C:     z = C;
      default: z = '0;
    endcase
  end

  // 49-bit unsigned arithmetic; bit 48 is the carry (or borrow on subtract).
  always_comb begin
    if (opm[OPM_SUB]) r = {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, cin});
    else              r = {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cin};
  end

  // Feedback always uses the real P register; PREG only picks the output tap.
  dsp_pipe_reg #(.W(P_W), .EN(1)) u_p (
    .CLK(CLK), .RST(RST), .ce_i(CEP), .d_i(r[P_W-1:0]), .q_o(p_q));

  dsp_pipe_reg #(.W(1), .EN(CARRYOUTREG)) u_co (
    .CLK(CLK), .RST(RST), .ce_i(CEP), .d_i(r[P_W]), .q_o(co));

  assign P         = (PREG != 0) ? p_q : r[P_W-1:0];
  assign PCOUT     = P;
  assign CARRYOUT  = co;
  assign CARRYOUTF = co;

`ifdef DSP_ACC_OVF_EN
  logic ovf_now, ovf_d, ovf_q;
  // Signed overflow: result sign disagrees with Z when the effective operand
  // signs agree (X same sign on add, opposite sign on subtract).
  assign ovf_now = (r[P_W-1] != z[P_W-1]) &&
                   (opm[OPM_SUB] ? (z[P_W-1] != x[P_W-1]) : (z[P_W-1] == x[P_W-1]));
  assign ovf_d   = ovf_now | (ovf_q & (opm[3:2] == Z_P));

  dsp_pipe_reg #(.W(1), .EN(1)) u_ovf (
    .CLK(CLK), .RST(RST), .ce_i(CEP), .d_i(ovf_d), .q_o(ovf_q));

  assign ACC_OVF = ovf_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{opm[6], opm[4], opm[OPM_CIN], D[17:DCAT_W], CARRYIN};
endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed self-checking bench for dsp_post_adder_acc at default parameters.
module tb_dsp_post_adder_acc;
  logic        CLK = 1'b0;
  logic        RST;
  logic        CEP, CECARRYIN, CEOPMODE;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [17:0] D, A, B;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;
`ifdef DSP_ACC_OVF_EN
  logic        ACC_OVF;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  dsp_post_adder_acc dut (
    .CLK(CLK), .RST(RST), .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .OPMODE(OPMODE), .M(M), .D(D), .A(A), .B(B), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT),
`ifdef DSP_ACC_OVF_EN
    .ACC_OVF(ACC_OVF),
`endif
    .CARRYOUTF(CARRYOUTF));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; CEP = 1'b1; CECARRYIN = 1'b1; CEOPMODE = 1'b1;
    OPMODE = 8'h00; M = '0; D = '0; A = '0; B = '0; C = '0; PCIN = '0; CARRYIN = 1'b0;
    tick(); tick();
    chk("rst_p", P, 0);
    chk("rst_pcout", PCOUT, 0);
    chk("rst_co", CARRYOUT, 0);
    chk("rst_cof", CARRYOUTF, 0);
    RST = 1'b0;

    // Load P=0x1234, then assert reset between edges.
    OPMODE = 8'h0C; C = 48'h1234;
    tick(); tick();
    chk("load_1234", P, 48'h1234);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_p", P, 0);
    chk("async_rst_pcout", PCOUT, 0);
    chk("async_rst_co", CARRYOUT, 0);
    chk("async_rst_cof", CARRYOUTF, 0);
    tick();
    RST = 1'b0;

    // C + M with M = -5: 100 - 5 = 95, unsigned carry out set.
    OPMODE = 8'h0D; C = 48'd100; M = 36'hF_FFFF_FFFB;
    tick(); tick();
    chk("add_p", P, 48'd95);
    chk("add_pcout", PCOUT, 48'd95);
    chk("add_co", CARRYOUT, 1);
    chk("add_cof", CARRYOUTF, 1);

    // Clear P, then accumulate M=3.
    OPMODE = 8'h0C; C = '0; M = 36'd3;
    tick(); tick();
    chk("acc_clear", P, 0);
    OPMODE = 8'h09;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("acc_%0d", i), P, 48'(3 * i));
    end
    chk("acc_co", CARRYOUT, 0);
    CEP = 1'b0; M = 36'd100;
    tick();
    chk("cep_hold", P, 48'd12);

    // 0 - (0 + 1) via OPMODE[5] carry-in: wraps to all ones with borrow bit.
    CEP = 1'b1; M = '0; OPMODE = 8'hAC; C = '0;
    tick(); tick(); tick();
    chk("sub_p", P, 48'hFFFF_FFFF_FFFF);
    chk("sub_co", CARRYOUT, 1);

    // -1 + 1 wraps to zero with carry; not a signed overflow.
    OPMODE = 8'h0F; C = 48'hFFFF_FFFF_FFFF; B = 18'd1;
    tick(); tick(); tick();
    chk("wrap_p", P, 0);
    chk("wrap_co", CARRYOUT, 1);
`ifdef DSP_ACC_OVF_EN
    chk("wrap_ovf", ACC_OVF, 0);
`endif

    // Max positive + 1 overflows.
    C = 48'h7FFF_FFFF_FFFF;
    tick();
    chk("ovf_p", P, 48'h8000_0000_0000);
    chk("ovf_co", CARRYOUT, 0);
`ifdef DSP_ACC_OVF_EN
    chk("ovf_set", ACC_OVF, 1);
`endif

    // Switch to Z=P with P frozen, then accumulate zero: flag stays sticky.
    CEP = 1'b0; OPMODE = 8'h0B; B = '0;
    tick();
    CEP = 1'b1;
    tick();
    chk("ovf_acc_p", P, 48'h8000_0000_0000);
`ifdef DSP_ACC_OVF_EN
    chk("ovf_sticky", ACC_OVF, 1);
`endif

    // New accumulation (Z=C) clears the flag.
    CEP = 1'b0; OPMODE = 8'h0C; C = 48'd5;
    tick();
    CEP = 1'b1;
    tick();
    chk("new_acc_p", P, 48'd5);
`ifdef DSP_ACC_OVF_EN
    chk("ovf_clear", ACC_OVF, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
